// File: rtl/itree_channel_scheduler.sv
// Purpose : round-robin scheduler sharing one i_tree anomaly datapath among NUM_CH channels.
// Latency : accept in T, tree strobe in T+1, result strobe in T+2+TREE_LAT, back in IDLE at T+3+TREE_LAT.
// Backpr. : one sample in flight; non-granted channels hold ch_valid/ch_data until their ch_ready pulse.
//
// Ports:
//   clk, reset (async, active-low)
//   ch_data/ch_valid/ch_ready  : per-channel sample request and one-hot accept pulse
//   flag_clear                 : per-channel clear of the sticky anomaly flags
//   tree_data_input/_valid     : sample and single-cycle strobe to the i_tree instance
//   tree_anomaly               : anomaly_detected back from the i_tree instance
//   result_valid/_ch/_anomaly  : one-cycle tagged result strobe
//   anomaly_flag               : sticky per-channel anomaly flags
//   busy                       : high whenever the FSM is not in IDLE
//   anomaly_cnt                : per-channel saturating 8-bit anomaly counters,
//                                present only when ITREE_SCHED_CNT_EN is defined
module itree_channel_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int TREE_LAT = 1,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        flag_clear,
  output logic [DATA_W-1:0]        tree_data_input,
  output logic                     tree_data_valid,
  input  logic                     tree_anomaly,
  output logic                     result_valid,
  output logic [CH_W-1:0]          result_ch,
  output logic                     result_anomaly,
  output logic [NUM_CH-1:0]        anomaly_flag,
`ifdef ITREE_SCHED_CNT_EN
  output logic [NUM_CH*8-1:0]      anomaly_cnt,
`endif
  output logic                     busy
);

  // TREE_LAT is at most 15, so the loaded value TREE_LAT-1 fits in 4 bits.
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                res_anom_q, res_anom_d;
  logic [NUM_CH-1:0]   flag_q, flag_d;
  logic [NUM_CH-1:0]   flag_set;

  // Arbiter results
  logic                req_any;
  logic [CH_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   grant_data;
  int                  arb_idx;
  logic [CH_W-1:0]     cand;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan offsets from the highest down so the smallest
  // offset from rr_ptr (the first requester at or after it) is assigned last.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_any   = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NUM_CH) begin
        arb_idx = arb_idx - NUM_CH;
      end
      cand = CH_W'(arb_idx);
      if (ch_valid[cand]) begin
        req_any   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        grant_data = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    data_d          = data_q;
    wcnt_d          = wcnt_q;
    res_anom_d      = res_anom_q;
    ch_ready        = '0;
    tree_data_valid = 1'b0;
    result_valid    = 1'b0;
    flag_set        = '0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          ch_ready = NUM_CH'(1) << grant_idx;
          grant_d  = grant_idx;
          data_d   = grant_data;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        tree_data_valid = 1'b1;
        wcnt_d          = WCNT_W'(TREE_LAT - 1);
        state_d         = WAIT;
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          res_anom_d = tree_anomaly;
          state_d    = RESULT;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      RESULT: begin
        result_valid = 1'b1;
        if (res_anom_q) begin
          flag_set = NUM_CH'(1) << grant_q;
        end
        if (grant_q == CH_W'(NUM_CH - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Set has priority over a coincident clear of the same bit.
    flag_d = (flag_q & ~flag_clear) | flag_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      wcnt_q     <= '0;
      res_anom_q <= 1'b0;
      flag_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      wcnt_q     <= wcnt_d;
      res_anom_q <= res_anom_d;
      flag_q     <= flag_d;
    end
  end

  assign tree_data_input = data_q;
  assign result_ch       = grant_q;
  assign result_anomaly  = res_anom_q;
  assign anomaly_flag    = flag_q;
  assign busy            = (state_q != IDLE);

`ifdef ITREE_SCHED_CNT_EN
  // ---------------------------------------------------------------------------
  // Per-channel saturating anomaly counters. They increment on the same
  // condition that sets the sticky flag; a coincident clear restarts at 1.
  // ---------------------------------------------------------------------------
  logic [7:0] cnt_q [NUM_CH];
  logic [7:0] cnt_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flag_clear[i]) begin
        cnt_d[i] = flag_set[i] ? 8'd1 : 8'd0;
      end else if (flag_set[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    anomaly_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      anomaly_cnt[i*8 +: 8] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_itree_channel_scheduler.sv
// Purpose : directed self-checking bench for itree_channel_scheduler.
// Latency : the i_tree is modelled as a TREE_LAT-stage pipeline flagging sample 8'hAB.
// Backpr. : requests are held by the bench until accepted, as a sensor front-end would.
module tb_itree_channel_scheduler;

`ifdef ITREE_SCHED_CNT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH-1:0]    flag_clear;
  logic [DW-1:0]     tree_data_input;
  logic              tree_data_valid;
  logic              tree_anomaly;
  logic              result_valid;
  logic [CHW-1:0]    result_ch;
  logic              result_anomaly;
  logic [NCH-1:0]    anomaly_flag;
  logic              busy;
`ifdef ITREE_SCHED_CNT_EN
  logic [NCH*8-1:0]  anomaly_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  itree_channel_scheduler #(
    .NUM_CH  (NCH),
    .DATA_W  (DW),
    .TREE_LAT(LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ch_data        (ch_data),
    .ch_valid       (ch_valid),
    .ch_ready       (ch_ready),
    .flag_clear     (flag_clear),
    .tree_data_input(tree_data_input),
    .tree_data_valid(tree_data_valid),
    .tree_anomaly   (tree_anomaly),
    .result_valid   (result_valid),
    .result_ch      (result_ch),
    .result_anomaly (result_anomaly),
    .anomaly_flag   (anomaly_flag),
`ifdef ITREE_SCHED_CNT_EN
    .anomaly_cnt    (anomaly_cnt),
`endif
    .busy           (busy)
  );

  // i_tree stand-in: anomaly_detected is valid LAT cycles after data_valid.
  logic [15:0] tree_pipe = '0;
  always @(posedge clk) begin
    tree_pipe <= {tree_pipe[14:0], tree_data_valid && (tree_data_input == 8'hAB)};
  end
  assign tree_anomaly = tree_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with the request already driven. Follows one
  // transaction to the IDLE cycle after its RESULT. clr is driven on
  // flag_clear during the RESULT cycle.
  task automatic expect_txn(input int ch, input logic [7:0] d, input logic anom,
                            input logic [3:0] clr);
    chk("accept_ready", ch_ready, 32'(1) << ch);
    chk("accept_busy", busy, 0);
    tick();
    chk("issue_valid", tree_data_valid, 1);
    chk("issue_data", tree_data_input, d);
    chk("issue_ready", ch_ready, 0);
    chk("issue_busy", busy, 1);
    repeat (LAT) begin
      tick();
      chk("wait_valid", tree_data_valid, 0);
      chk("wait_result", result_valid, 0);
      chk("wait_data", tree_data_input, d);
    end
    tick();
    chk("res_valid", result_valid, 1);
    chk("res_ch", result_ch, ch);
    chk("res_anom", result_anomaly, anom);
    chk("res_data", tree_data_input, d);
    chk("res_tvalid", tree_data_valid, 0);
    flag_clear = clr;
    tick();
    flag_clear = '0;
    chk("post_valid", result_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, ch_ready, 0);
    chk({tag, "_tdata"}, tree_data_input, 0);
    chk({tag, "_tvalid"}, tree_data_valid, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_rch"}, result_ch, 0);
    chk({tag, "_ranom"}, result_anomaly, 0);
    chk({tag, "_flag"}, anomaly_flag, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef ITREE_SCHED_CNT_EN
    chk({tag, "_cnt"}, anomaly_cnt, 0);
`endif
  endtask

  initial begin
    reset      = 1'b0;
    ch_valid   = '0;
    ch_data    = '0;
    flag_clear = '0;
    repeat (2) tick();
    chk_all_zero("rst");

    // Idle after reset release
    reset = 1'b1;
    repeat (8) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_ready", ch_ready, 0);
    end

    // Fairness: all channels held, grants 0,1,2,3,0 back to back
    ch_data  = {8'hFF, 8'h33, 8'h22, 8'h11};
    ch_valid = 4'b1111;
    #1;
    expect_txn(0, 8'h11, 1'b0, 4'b0000);
    expect_txn(1, 8'h22, 1'b0, 4'b0000);
    expect_txn(2, 8'h33, 1'b0, 4'b0000);
    expect_txn(3, 8'hFF, 1'b0, 4'b0000);
    expect_txn(0, 8'h11, 1'b0, 4'b0000);
    ch_valid = '0;
    #1;
    chk("fair_flag", anomaly_flag, 0);

    // Single request on ch2 with an anomalous sample
    ch_data  = {8'hFF, 8'hAB, 8'h22, 8'h11};
    ch_valid = 4'b0100;
    #1;
    expect_txn(2, 8'hAB, 1'b1, 4'b0000);
    ch_valid = '0;
    chk("single_flag", anomaly_flag, 4'b0100);

    // Clear coinciding with a set: set wins; a later clear takes effect
    ch_valid = 4'b0100;
    #1;
    expect_txn(2, 8'hAB, 1'b1, 4'b0100);
    ch_valid = '0;
    chk("clr_set_flag", anomaly_flag, 4'b0100);
    flag_clear = 4'b0100;
    tick();
    flag_clear = '0;
    chk("clr_flag", anomaly_flag, 4'b0000);

    // Move rr_ptr to 1 so a missing pointer reset would grant ch1 below
    ch_data  = {8'hFF, 8'h33, 8'hAB, 8'h00};
    ch_valid = 4'b0001;
    #1;
    expect_txn(0, 8'h00, 1'b0, 4'b0000);
    ch_valid = 4'b0010;
    #1;
    chk("mid_ready", ch_ready, 4'b0010);
    tick();
    ch_valid = '0;
    chk("mid_issue", tree_data_valid, 1);
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    reset = 1'b1;
    repeat (LAT + 4) begin
      tick();
      chk("mid_norv", result_valid, 0);
      chk("mid_flag", anomaly_flag, 0);
    end
    ch_valid = 4'b0011;
    #1;
    expect_txn(0, 8'h00, 1'b0, 4'b0000);
    ch_valid = '0;

`ifdef ITREE_SCHED_CNT_EN
    // Saturating counter on ch0, then clear coinciding with an increment
    ch_data  = {8'hFF, 8'h33, 8'h22, 8'hAB};
    ch_valid = 4'b0001;
    #1;
    for (int i = 1; i <= 260; i++) begin
      expect_txn(0, 8'hAB, 1'b1, 4'b0000);
      chk("cnt_sat", anomaly_cnt[7:0], (i > 255) ? 255 : i);
    end
    expect_txn(0, 8'hAB, 1'b1, 4'b0001);
    ch_valid = '0;
    chk("cnt_clr_inc", anomaly_cnt[7:0], 1);
    chk("cnt_clr_flag", anomaly_flag, 4'b0001);
    chk("cnt_others", anomaly_cnt[31:8], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/itree_channel_scheduler.md
# itree_channel_scheduler

Round-robin scheduler that shares one `i_tree` anomaly-detection datapath among `NUM_CH` sensor channels. It accepts one sample at a time from the requesting channels and issues it to the tree as a single-cycle `data_valid` strobe. It waits the tree's fixed result latency, then captures `anomaly_detected` into per-channel sticky flags and a tagged result strobe. It sits between the sensor front-ends and the `i_tree` instance.

## Interface
Parameters:
- `NUM_CH`, 4: number of sensor channels (2..16).
- `DATA_W`, 8: sample width; matches the `i_tree` `data_input` width.
- `TREE_LAT`, 1: cycles from the `i_tree` `data_valid` cycle to a valid `anomaly_detected` (1..15).
- `CH_W`, $clog2(NUM_CH): channel index width (derived).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ch_data`  in  NUM_CH*DATA_W  channel samples; channel i occupies bits [i*DATA_W +: DATA_W].
- `ch_valid`  in  NUM_CH  per-channel sample request.
- `ch_ready`  out  NUM_CH  one-hot accept pulse; the sample transfers when `ch_valid[i] & ch_ready[i]`.
- `flag_clear`  in  NUM_CH  clears the sticky anomaly flags.
- `tree_data_input`  out  DATA_W  to `i_tree` `data_input`.
- `tree_data_valid`  out  1  to `i_tree` `data_valid`.
- `tree_anomaly`  in  1  from `i_tree` `anomaly_detected`.
- `result_valid`  out  1  one-cycle result strobe.
- `result_ch`  out  CH_W  channel tagged with the current result.
- `result_anomaly`  out  1  anomaly bit for the current result.
- `anomaly_flag`  out  NUM_CH  sticky per-channel anomaly flags.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESULT.
- IDLE:
  - When any `ch_valid` bit is set, grant the first requester at or after `rr_ptr`, wrapping from NUM_CH-1 to 0.
  - Drive `ch_ready[grant]`=1 combinationally in that cycle only.
  - Latch that channel's sample and its index, then go to ISSUE.
  - If no channel requests, `ch_ready`=0 and the FSM stays in IDLE.
- ISSUE:
  - `tree_data_valid`=1 for exactly one cycle.
  - `tree_data_input` holds the latched sample from ISSUE through RESULT.
  - Load the wait counter with TREE_LAT-1, then go to WAIT.
- WAIT:
  - Counts down. When the counter is 0, sample `tree_anomaly` on that edge into `result_anomaly`, then go to RESULT.
- RESULT:
  - `result_valid`=1 for one cycle, with `result_ch` set to the granted index.
  - If `result_anomaly`=1, set `anomaly_flag[result_ch]`.
  - Set `rr_ptr` to (grant+1) mod NUM_CH, then go to IDLE.
- `flag_clear[i]`=1 clears `anomaly_flag[i]` on the next edge.
  - If a clear and a set target the same bit in the same cycle, the set wins.
- `tree_data_valid` is 0 in every state except ISSUE.
- `ch_ready` is 0 in every state except IDLE.
- Reset values: `ch_ready`=0, `tree_data_input`=0, `tree_data_valid`=0, `result_valid`=0, `result_ch`=0, `result_anomaly`=0, `anomaly_flag`=0, `busy`=0, `rr_ptr`=0, state=IDLE.
- Reset mid-operation (assertion in any state):
  - Abandons the in-flight sample with no result strobe and no flag update.
  - After deassertion, arbitration restarts at channel 0.

## Timing
- Accept in cycle T (IDLE) → `tree_data_valid` in T+1 → `tree_anomaly` sampled on the edge that ends cycle T+1+TREE_LAT → `result_valid` in T+2+TREE_LAT → IDLE in T+3+TREE_LAT.
- Throughput is one sample per TREE_LAT+3 cycles. With the defaults, that is 4 cycles per sample.
- Channels that are not granted hold `ch_valid` and `ch_data` stable until they are accepted. The scheduler does not buffer them.
- `ch_valid` is sampled only in IDLE. A request that drops before it is accepted is ignored.
- A channel with `ch_valid` held continuously is granted at least once every NUM_CH accepts.

## Configuration
- `ITREE_SCHED_CNT_EN` defined:
  - Adds output `anomaly_cnt` of width NUM_CH*8, with one 8-bit counter per channel.
  - A counter increments in RESULT when `result_anomaly`=1, saturates at 255, and resets to 0.
  - `flag_clear[i]` also zeroes counter i. If a clear and an increment coincide, the result is 1.
- `ITREE_SCHED_CNT_EN` undefined: the port and the counters are absent. All other behaviour is identical.

## Test plan
- Reset: assert `reset`=0 → all outputs 0. Deassert, with no `ch_valid` → `busy`=0 indefinitely.
- Single request: `ch_valid`=4'b0100, ch2 sample 8'hAB, with the tree flagging 8'hAB → `ch_ready`=4'b0100 at T, `tree_data_valid`=1 with 8'hAB at T+1, `result_valid`=1 with `result_ch`=2 and `result_anomaly`=1 at T+3, `anomaly_flag`=4'b0100.
- Fairness: `ch_valid`=4'b1111 held, with ch3 sample 8'hFF → grants in order 0,1,2,3,0 at 4-cycle spacing. `result_anomaly`=0 for ch3 and `anomaly_flag[3]` stays 0.
- Clear versus set: `flag_clear[2]`=1 in the same cycle as an anomaly RESULT for ch2 → `anomaly_flag[2]` stays 1. `flag_clear[2]`=1 on the next cycle → `anomaly_flag[2]`=0.
- Reset mid-operation: pulse `reset` low during WAIT for ch1 → no `result_valid` and `anomaly_flag` stays 0. After release, `ch_valid`=4'b0011 → ch0 is granted first.
- `ITREE_SCHED_CNT_EN` with TREE_LAT=3: 260 anomalous ch0 samples → `result_valid` 5 cycles after each accept, and `anomaly_cnt[7:0]` saturates at 255.
